poly_negacyclic_fold: RTL and testbench

Receive-side companion to the polynomial multiplier in the FV encryption datapath. It accepts the 2N-1 linear-convolution coefficients the multiplier streams out, each already reduced mod Q. It folds them into an N-coefficient product modulo (x^N + 1), using c[i] = a[i] − a[i+N] mod Q, and streams the N results to the next stage. Both sides use valid/ready handshakes, and one polynomial is processed at a time.

---
 rtl/fv_pkg.sv | 16 +
 rtl/poly_mod_sub.sv | 23 ++
 rtl/poly_negacyclic_fold.sv | 120 ++++++++++++
 tb/tb_poly_negacyclic_fold.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fv_pkg.sv
// Shared types and width helpers for the FV encryption datapath.
package fv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FOLD  = 2'd2,
        DRAIN = 2'd3
    } fold_state_e;

    // One extra bit above the coefficient width holds the borrow of a - b.
    function automatic int mod_sub_width(input int qw);
        return qw + 1;
    endfunction

endpackage

// File: rtl/poly_mod_sub.sv
// Combinational modular subtract: o_d = (i_a - i_b) mod Q, for i_a, i_b < Q.
module poly_mod_sub
    import fv_pkg::*;
#(
    parameter int             QW = 64,
    parameter logic [QW-1:0]  Q  = QW'(64'hFFFF_FFFF_0000_0001)
) (
    input  logic [QW-1:0] i_a,
    input  logic [QW-1:0] i_b,
    output logic [QW-1:0] o_d
);

    localparam int SW = mod_sub_width(QW);

    logic [SW-1:0] w_diff;
    logic          w_borrow;

    assign w_diff   = {1'b0, i_a} - {1'b0, i_b};
    // The top bit of the widened difference is set exactly when i_a < i_b.
    assign w_borrow = w_diff[SW-1];
    assign o_d      = w_diff[QW-1:0] + (w_borrow ? Q : '0);

endmodule

// File: rtl/poly_negacyclic_fold.sv
// Folds 2N-1 linear-convolution coefficients into N coefficients mod (x^N + 1):
// c[i] = a[i] - a[i+N] mod Q, one polynomial in flight at a time.
module poly_negacyclic_fold
    import fv_pkg::*;
#(
    parameter int             N  = 16,
    parameter int             QW = 64,
    parameter logic [QW-1:0]  Q  = QW'(64'hFFFF_FFFF_0000_0001)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [QW-1:0] in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [QW-1:0] out_data,
    output logic          out_last,
    output logic          err
);

    localparam int IW = $clog2(2 * N);
    localparam int OW = $clog2(N);

    fold_state_e   r_state;
    logic [IW-1:0] r_in_idx;
    logic [OW-1:0] r_out_idx;
    logic          r_err;
    logic [QW-1:0] r_buf [N];

    logic          w_in_hs;
    logic          w_out_hs;
    logic          w_in_at_last;
    logic [OW-1:0] w_buf_idx;
    logic [QW-1:0] w_sub;

    assign in_ready     = (r_state == LOAD) || (r_state == FOLD);
    assign out_valid    = (r_state == DRAIN);
    assign w_in_hs      = in_valid && in_ready;
    assign w_out_hs     = out_valid && out_ready;
    assign w_in_at_last = (r_in_idx == IW'(2 * N - 2));

    // During FOLD the high half of the input stream lands on buf[k-N].
    assign w_buf_idx = (r_state == FOLD) ? OW'(r_in_idx - IW'(N)) : OW'(r_in_idx);

    assign out_data = r_buf[r_out_idx];
    assign out_last = out_valid && (r_out_idx == OW'(N - 1));
    assign err      = r_err;

    poly_mod_sub #(
        .QW (QW),
        .Q  (Q)
    ) u_mod_sub (
        .i_a (r_buf[w_buf_idx]),
        .i_b (in_data),
        .o_d (w_sub)
    );

    // NOTE: the coefficient buffer has no reset; every entry is rewritten
    // during LOAD before DRAIN can read it, so reset state is never observed.
    always_ff @(posedge clk) begin
        if (w_in_hs) begin
            r_buf[w_buf_idx] <= (r_state == FOLD) ? w_sub : in_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_in_idx  <= '0;
            r_out_idx <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_in_hs && (in_last != w_in_at_last)) begin
                r_err <= 1'b1;
            end

            case (r_state)
                IDLE: r_state <= LOAD;

                LOAD: begin
                    if (w_in_hs) begin
                        r_in_idx <= r_in_idx + 1'b1;
                        if (r_in_idx == IW'(N - 1)) begin
                            r_state <= FOLD;
                        end
                    end
                end

                FOLD: begin
                    if (w_in_hs) begin
                        if (w_in_at_last) begin
                            r_in_idx <= '0;
                            r_state  <= DRAIN;
                        end else begin
                            r_in_idx <= r_in_idx + 1'b1;
                        end
                    end
                end

                DRAIN: begin
                    if (w_out_hs) begin
                        if (r_out_idx == OW'(N - 1)) begin
                            r_out_idx <= '0;
                            r_state   <= LOAD;
                        end else begin
                            r_out_idx <= r_out_idx + 1'b1;
                        end
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_poly_negacyclic_fold.sv
// Scoreboard bench: a small N=4/Q=17 instance for directed vectors and a
// default-parameter instance under random backpressure.
module tb_poly_negacyclic_fold;

    localparam logic [63:0] QB = 64'hFFFF_FFFF_0000_0001;
    localparam int          NB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Small instance signals
    logic       s_rst_n, s_in_valid, s_in_ready, s_in_last;
    logic       s_out_valid, s_out_ready, s_out_last, s_err;
    logic [7:0] s_in_data, s_out_data;

    // Big instance signals
    logic        b_rst_n, b_in_valid, b_in_ready, b_in_last;
    logic        b_out_valid, b_out_ready, b_out_last, b_err;
    logic [63:0] b_in_data, b_out_data;

    logic [8:0]  s_exp_q [$];
    logic [64:0] b_exp_q [$];

    poly_negacyclic_fold #(.N(4), .QW(8), .Q(8'd17)) u_small (
        .clk       (clk),
        .rst_n     (s_rst_n),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_data   (s_in_data),
        .in_last   (s_in_last),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_data  (s_out_data),
        .out_last  (s_out_last),
        .err       (s_err)
    );

    poly_negacyclic_fold u_big (
        .clk       (clk),
        .rst_n     (b_rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_last   (b_in_last),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_last  (b_out_last),
        .err       (b_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_sub(input logic [63:0] a, input logic [63:0] b);
        return (a >= b) ? (a - b) : (a + (QB - b));
    endfunction

    task automatic push_small(input logic [7:0] e [4]);
        for (int j = 0; j < 4; j++) s_exp_q.push_back({(j == 3), e[j]});
    endtask

    task automatic send_small(input logic [7:0] v [7], input int last_k,
                              input int first, input int cnt);
        int t;
        for (int k = first; k < first + cnt; k++) begin
            @(negedge clk);
            s_in_valid = 1'b1;
            s_in_data  = v[k];
            s_in_last  = (k == last_k);
            t = 0;
            while (!s_in_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) check("s_in_accept_timeout", s_in_ready, 1);
        end
        @(negedge clk);
        s_in_valid = 1'b0;
        s_in_last  = 1'b0;
    endtask

    task automatic wait_small_drain();
        int t = 0;
        while (s_exp_q.size() > 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("s_drain", s_exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // Small-instance output scoreboard
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (s_out_valid && s_out_ready) begin
                check("s_exp_avail", (s_exp_q.size() > 0), 1);
                if (s_exp_q.size() > 0) begin
                    e = s_exp_q.pop_front();
                    check("s_out_data", s_out_data, e[7:0]);
                    check("s_out_last", s_out_last, e[8]);
                end
            end
        end
    end

    // Big-instance output: random ready, hold check, scoreboard
    initial begin
        logic        pv = 1'b0;
        logic [63:0] pd;
        logic        pl;
        logic [64:0] e;
        b_out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (pv) begin
                check("b_hold_valid", b_out_valid, 1);
                check("b_hold_data", b_out_data, pd);
                check("b_hold_last", b_out_last, pl);
            end
            if (b_out_valid) check("b_drain_in_ready", b_in_ready, 0);
            b_out_ready = 1'($urandom_range(0, 1));
            if (b_out_valid && b_out_ready) begin
                check("b_exp_avail", (b_exp_q.size() > 0), 1);
                if (b_exp_q.size() > 0) begin
                    e = b_exp_q.pop_front();
                    check("b_out_data", b_out_data, e[63:0]);
                    check("b_out_last", b_out_last, e[64]);
                end
            end
            pv = b_out_valid && !b_out_ready;
            pd = b_out_data;
            pl = b_out_last;
        end
    end

    initial begin
        logic [7:0]  v_basic [7] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
        logic [7:0]  e_basic [4] = '{8'd13, 8'd13, 8'd13, 8'd4};
        logic [7:0]  v_nouf  [7] = '{8'd9, 8'd9, 8'd9, 8'd9, 8'd2, 8'd3, 8'd0};
        logic [7:0]  e_nouf  [4] = '{8'd7, 8'd6, 8'd9, 8'd9};
        logic [7:0]  v_wrap  [7] = '{8'd0, 8'd16, 8'd0, 8'd0, 8'd16, 8'd0, 8'd16};
        logic [7:0]  e_wrap  [4] = '{8'd1, 8'd16, 8'd1, 8'd0};
        logic [63:0] coef [2*NB-1];
        int k, t;

        s_rst_n = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_in_last = 1'b0; s_out_ready = 1'b1;
        b_rst_n = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_in_ready", s_in_ready, 0);
        check("rst_out_valid", s_out_valid, 0);
        check("rst_out_last", s_out_last, 0);
        check("rst_err", s_err, 0);
        check("rst_b_in_ready", b_in_ready, 0);
        s_rst_n = 1'b1;
        b_rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_rise", s_in_ready, 1);

        // Directed vectors
        push_small(e_basic);
        send_small(v_basic, 6, 0, 7);
        wait_small_drain();
        check("basic_err", s_err, 0);

        push_small(e_nouf);
        send_small(v_nouf, 6, 0, 7);
        wait_small_drain();

        push_small(e_wrap);
        send_small(v_wrap, 6, 0, 7);
        wait_small_drain();

        // Reset after five inputs, then a full polynomial
        send_small(v_nouf, 6, 0, 5);
        s_rst_n = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", s_in_ready, 0);
        check("midrst_out_valid", s_out_valid, 0);
        s_rst_n = 1'b1;
        push_small(e_basic);
        send_small(v_basic, 6, 0, 7);
        wait_small_drain();
        check("midrst_err", s_err, 0);

        // Framing error: in_last on k = 3
        check("frm_err_before", s_err, 0);
        push_small(e_basic);
        send_small(v_basic, 3, 0, 4);
        check("frm_err_rise", s_err, 1);
        send_small(v_basic, 3, 4, 3);
        wait_small_drain();
        check("frm_err_sticky", s_err, 1);
        s_rst_n = 1'b0;
        @(negedge clk);
        s_rst_n = 1'b1;
        check("frm_err_cleared", s_err, 0);

        // Random backpressure, default parameters
        for (int p = 0; p < 20; p++) begin
            for (int i = 0; i < 2 * NB - 1; i++) coef[i] = {$urandom, $urandom} % QB;
            for (int j = 0; j < NB; j++) begin
                b_exp_q.push_back({(j == NB - 1),
                                   (j < NB - 1) ? ref_sub(coef[j], coef[j+NB]) : coef[j]});
            end
            k = 0;
            t = 0;
            while (k < 2 * NB - 1 && t < 5000) begin
                @(negedge clk);
                b_in_valid = 1'($urandom_range(0, 1));
                b_in_data  = coef[k];
                b_in_last  = (k == 2 * NB - 2);
                if (b_in_valid && b_in_ready) k++;
                t++;
            end
            if (t >= 5000) check("b_in_timeout", k, 2 * NB - 1);
        end
        @(negedge clk);
        b_in_valid = 1'b0;
        t = 0;
        while (b_exp_q.size() > 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("b_drain", b_exp_q.size(), 0);
        check("b_err", b_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
